// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: CPU-loaded pattern RAM replayed as state-word pairs into rgb_led.
// Optional build macro LED_SEQ_IRQ_EN adds a registered irq output (done & irq_en).
module led_pattern_sequencer #(
  parameter int DEPTH  = 16,
  parameter int TICK_W = 32
) (
  input  logic        pclk,
  input  logic        nreset,
  input  logic        bus_write_en,
  input  logic        bus_read_en,
  input  logic [7:0]  bus_addr,
  input  logic [31:0] bus_write_data,
  output logic [31:0] bus_read_data,
  output logic        led_write_en,
  output logic [7:0]  led_addr,
  output logic [31:0] led_write_data
`ifdef LED_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [7:0] MAX_STEPS = 8'(DEPTH / 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WR1   = 3'd2,
    S_WR2   = 3'd3,
    S_DWELL = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [31:0]       ram [DEPTH];
  logic [AW-1:0]     ptr;
  logic [AW-1:0]     fetch_idx;

  logic              run;
  logic              loop_en;
  logic              irq_en_bit;
  logic [7:0]        num_steps;
  logic [TICK_W-1:0] step_ticks;
  logic              done;

  logic [7:0]        step;
  logic [7:0]        step_inc;
  logic [TICK_W-1:0] dwell_cnt;
  logic [31:0]       word_a_p1;
  logic [31:0]       word_b_p1;

  logic              set_done;
  logic              clr_run;
  logic              step_clr;
  logic              step_adv;
  logic              last_tick;
  logic              busy;

  logic [2:0]        sel;
  logic              wr_ctrl;
  logic              wr_ticks;
  logic              wr_status;
  logic              wr_ptr;
  logic              wr_data;
  logic              rd_any;
  logic [31:0]       rd_mux;
  logic              unused_addr;

  function automatic logic [7:0] clamp_steps(input logic [7:0] n);
    return (n > MAX_STEPS) ? MAX_STEPS : n;
  endfunction

  function automatic logic [TICK_W-1:0] eff_ticks(input logic [TICK_W-1:0] t);
    return (t == '0) ? TICK_W'(1) : t;
  endfunction

  assign sel         = bus_addr[4:2];
  assign wr_ctrl     = bus_write_en && (sel == 3'd0);
  assign wr_ticks    = bus_write_en && (sel == 3'd1);
  assign wr_status   = bus_write_en && (sel == 3'd2);
  assign wr_ptr      = bus_write_en && (sel == 3'd3);
  assign wr_data     = bus_write_en && (sel == 3'd4);
  assign rd_any      = bus_read_en && !bus_write_en;
  assign unused_addr = ^{bus_addr[7:5], bus_addr[1:0]};

  assign busy      = (state != S_IDLE);
  assign step_inc  = step + 8'd1;
  assign last_tick = (dwell_cnt <= TICK_W'(1));
  assign fetch_idx = AW'({step, 1'b0});

  // ---------------- CPU register file ----------------
  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      run        <= 1'b0;
      loop_en    <= 1'b0;
      num_steps  <= 8'd0;
      step_ticks <= '0;
      done       <= 1'b0;
      ptr        <= '0;
    end else begin
      // A CPU write to CTRL in the same cycle as an FSM run-clear wins.
      if (clr_run) run <= 1'b0;
      if (wr_ctrl) begin
        run       <= bus_write_data[0];
        loop_en   <= bus_write_data[1];
        num_steps <= clamp_steps(bus_write_data[15:8]);
      end
      if (wr_ticks) step_ticks <= bus_write_data[TICK_W-1:0];
      done <= set_done | (done & ~(wr_status & bus_write_data[1]));
      if (wr_ptr)       ptr <= bus_write_data[AW-1:0];
      else if (wr_data) ptr <= ptr + AW'(1);
    end
  end

`ifdef LED_SEQ_IRQ_EN
  logic irq_en;

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= bus_write_data[2];
      irq <= done & irq_en;
    end
  end

  assign irq_en_bit = irq_en;
`else
  assign irq_en_bit = 1'b0;
`endif

  // Pattern RAM: no reset, read-before-write on a same-edge collision.
  always_ff @(posedge pclk) begin
    if (wr_data) ram[ptr] <= bus_write_data;
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      3'd0:    rd_mux = {16'h0, num_steps, 5'h0, irq_en_bit, loop_en, run};
      3'd1:    rd_mux = 32'(step_ticks);
      3'd2:    rd_mux = {16'h0, step, 6'h0, done, busy};
      3'd3:    rd_mux = 32'(ptr);
      3'd4:    rd_mux = ram[ptr];
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset)     bus_read_data <= '0;
    else if (rd_any) bus_read_data <= rd_mux;
  end

  // ---------------- FSM state register and sequencing datapath ----------------
  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      step      <= 8'd0;
      dwell_cnt <= '0;
      word_a_p1 <= '0;
      word_b_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (step_clr)      step <= 8'd0;
      else if (step_adv) step <= step_inc;
      if (state == S_WR2)        dwell_cnt <= eff_ticks(step_ticks);
      else if (state == S_DWELL) dwell_cnt <= dwell_cnt - TICK_W'(1);
      if (state == S_FETCH) begin
        word_a_p1 <= ram[fetch_idx];
        word_b_p1 <= ram[fetch_idx | AW'(1)];
      end
    end
  end

  // Step advance/wrap/finish is decided on the last dwell cycle so that a
  // step costs exactly FETCH + WR1 + WR2 + dwell cycles.
  always_comb begin
    state_nxt = state;
    set_done  = 1'b0;
    clr_run   = 1'b0;
    step_clr  = 1'b0;
    step_adv  = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          if (num_steps == 8'd0) begin
            set_done = 1'b1;
            clr_run  = 1'b1;
          end else begin
            step_clr  = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      S_FETCH: state_nxt = run ? S_WR1 : S_IDLE;
      S_WR1:   state_nxt = S_WR2;
      S_WR2:   state_nxt = S_DWELL;
      S_DWELL: begin
        if (!run) begin
          state_nxt = S_IDLE;
        end else if (last_tick) begin
          if (step_inc >= num_steps) begin
            if (loop_en && (num_steps != 8'd0)) begin
              step_clr  = 1'b1;
              state_nxt = S_FETCH;
            end else begin
              set_done  = 1'b1;
              clr_run   = 1'b1;
              state_nxt = S_IDLE;
            end
          end else begin
            step_adv  = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    led_write_en   = 1'b0;
    led_addr       = 8'h00;
    led_write_data = 32'h0;
    case (state)
      S_WR1: begin
        led_write_en   = 1'b1;
        led_addr       = 8'h04;
        led_write_data = word_a_p1;
      end
      S_WR2: begin
        led_write_en   = 1'b1;
        led_addr       = 8'h08;
        led_write_data = word_b_p1;
      end
      default: begin
        led_write_en   = 1'b0;
        led_addr       = 8'h00;
        led_write_data = 32'h0;
      end
    endcase
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer (define LED_SEQ_IRQ_EN to include irq checks).
module tb_led_pattern_sequencer;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_TICKS  = 8'h04;
  localparam logic [7:0] A_STATUS = 8'h08;
  localparam logic [7:0] A_PTR    = 8'h0C;
  localparam logic [7:0] A_DATA   = 8'h10;

  logic        pclk = 1'b0;
  logic        nreset = 1'b0;
  logic        bus_write_en = 1'b0;
  logic        bus_read_en = 1'b0;
  logic [7:0]  bus_addr = 8'h00;
  logic [31:0] bus_write_data = 32'h0;
  logic [31:0] bus_read_data;
  logic        led_write_en;
  logic [7:0]  led_addr;
  logic [31:0] led_write_data;
`ifdef LED_SEQ_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] pat [6] = '{32'h80FF0000, 32'h8000FF00, 32'h80112233,
                           32'h00445566, 32'h81778899, 32'h80AABBCC};

  led_pattern_sequencer dut (
    .pclk           (pclk),
    .nreset         (nreset),
    .bus_write_en   (bus_write_en),
    .bus_read_en    (bus_read_en),
    .bus_addr       (bus_addr),
    .bus_write_data (bus_write_data),
    .bus_read_data  (bus_read_data),
    .led_write_en   (led_write_en),
    .led_addr       (led_addr),
    .led_write_data (led_write_data)
`ifdef LED_SEQ_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  always #5 pclk = ~pclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge pclk);
    bus_write_en   = 1'b1;
    bus_addr       = a;
    bus_write_data = d;
    @(negedge pclk);
    bus_write_en   = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge pclk);
    bus_read_en = 1'b1;
    bus_addr    = a;
    @(negedge pclk);
    bus_read_en = 1'b0;
    d = bus_read_data;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    nreset = 1'b0;
    repeat (3) @(negedge pclk);
    checks++;
    if ({led_write_en, led_addr, led_write_data, bus_read_data} !== 73'h0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b addr=%h data=%h rd=%h required all 0",
               led_write_en, led_addr, led_write_data, bus_read_data);
    end
    nreset = 1'b1;
    bus_rd(A_CTRL, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h required 0", d); end
    bus_rd(A_TICKS, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_ticks: got %h required 0", d); end
    bus_rd(A_STATUS, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h required 0", d); end
    bus_rd(A_PTR, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_ptr: got %h required 0", d); end
`ifdef LED_SEQ_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
`endif
  endtask

  task automatic test_registers();
    logic [31:0] d;
    bus_wr(A_TICKS, 32'hDEADBEEF);
    bus_rd(A_TICKS, d);
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL ticks_rw: got %h required deadbeef", d); end
    bus_wr(A_CTRL, 32'h0000C802);
    bus_rd(A_CTRL, d);
    checks++;
    if (d !== 32'h00000802) begin errors++; $display("FAIL ctrl_clamp: got %h required 00000802", d); end
    bus_wr(8'h1C, 32'hFFFFFFFF);
    bus_rd(8'h1C, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_1c: got %h required 0", d); end
    bus_rd(8'h14, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_14: got %h required 0", d); end
    bus_rd(A_CTRL, d);
    @(negedge pclk);
    bus_write_en   = 1'b1;
    bus_read_en    = 1'b1;
    bus_addr       = A_TICKS;
    bus_write_data = 32'd7;
    @(negedge pclk);
    bus_write_en = 1'b0;
    bus_read_en  = 1'b0;
    checks++;
    if (bus_read_data !== 32'h00000802) begin
      errors++;
      $display("FAIL write_over_read: got %h required held 00000802", bus_read_data);
    end
    bus_rd(A_TICKS, d);
    checks++;
    if (d !== 32'd7) begin errors++; $display("FAIL ticks_after_wr: got %h required 7", d); end
    bus_wr(A_CTRL, 32'h0);
  endtask

  task automatic test_single_step();
    logic [31:0] d;
    int nwr = 0;
    int busy_k = -1;
    int done_k = -1;
    bus_wr(A_PTR, 32'h0);
    for (int i = 0; i < 6; i++) bus_wr(A_DATA, pat[i]);
    bus_rd(A_PTR, d);
    checks++;
    if (d !== 32'd6) begin errors++; $display("FAIL ptr_incr: got %0d required 6", d); end
    bus_wr(A_TICKS, 32'd5);
    bus_wr(A_CTRL, 32'h0101);
    bus_addr    = A_STATUS;
    bus_read_en = 1'b1;
    for (int k = 2; k <= 14; k++) begin
      @(negedge pclk);
      if (led_write_en) begin
        nwr++;
        checks++;
        if (nwr == 1 && {k[7:0], led_addr, led_write_data} !== {8'd3, 8'h04, pat[0]}) begin
          errors++;
          $display("FAIL single_wr1: got k=%0d addr=%h data=%h required k=3 addr=04 data=%h",
                   k, led_addr, led_write_data, pat[0]);
        end
        if (nwr == 2 && {k[7:0], led_addr, led_write_data} !== {8'd4, 8'h08, pat[1]}) begin
          errors++;
          $display("FAIL single_wr2: got k=%0d addr=%h data=%h required k=4 addr=08 data=%h",
                   k, led_addr, led_write_data, pat[1]);
        end
      end else begin
        checks++;
        if ({led_addr, led_write_data} !== 40'h0) begin
          errors++;
          $display("FAIL idle_outputs: got addr=%h data=%h required 0", led_addr, led_write_data);
        end
      end
      if (bus_read_data[0] && busy_k < 0) busy_k = k;
      if (bus_read_data[1] && done_k < 0) begin
        done_k = k;
        checks++;
        if (bus_read_data[0] !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done: got %b required 0", bus_read_data[0]);
        end
      end
    end
    bus_read_en = 1'b0;
    checks++;
    if (nwr != 2) begin errors++; $display("FAIL single_nwr: got %0d required 2", nwr); end
    checks++;
    if (busy_k != 3 || done_k != 11) begin
      errors++;
      $display("FAIL single_timing: got busy_k=%0d done_k=%0d required 3 and 11", busy_k, done_k);
    end
    bus_rd(A_CTRL, d);
    checks++;
    if (d !== 32'h0100) begin errors++; $display("FAIL run_cleared: got %h required 00000100", d); end
    bus_wr(A_STATUS, 32'h0);
    bus_rd(A_STATUS, d);
    checks++;
    if (d[1] !== 1'b1) begin errors++; $display("FAIL done_w0_keeps: got %b required 1", d[1]); end
    bus_wr(A_STATUS, 32'h2);
    bus_rd(A_STATUS, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL done_w1c: got %h required 0", d); end
  endtask

  task automatic test_loop();
    logic [31:0] d;
    int nwr = 0;
    int prev_step = 0;
    logic saw_wrap = 1'b0;
    logic saw_done = 1'b0;
    int exp_k;
    logic [7:0] exp_addr;
    logic [31:0] exp_data;
    bus_wr(A_TICKS, 32'd2);
    bus_wr(A_CTRL, 32'h0303);
    bus_addr    = A_STATUS;
    bus_read_en = 1'b1;
    for (int k = 2; k <= 31; k++) begin
      @(negedge pclk);
      if (led_write_en) begin
        exp_k    = 3 + 5 * (nwr / 2) + (nwr % 2);
        exp_addr = (nwr % 2 == 1) ? 8'h08 : 8'h04;
        exp_data = pat[2 * ((nwr / 2) % 3) + (nwr % 2)];
        checks++;
        if (k != exp_k || led_addr !== exp_addr || led_write_data !== exp_data) begin
          errors++;
          $display("FAIL loop_wr%0d: got k=%0d addr=%h data=%h required k=%0d addr=%h data=%h",
                   nwr, k, led_addr, led_write_data, exp_k, exp_addr, exp_data);
        end
        nwr++;
      end
      if (prev_step == 2 && bus_read_data[15:8] == 8'd0) saw_wrap = 1'b1;
      prev_step = int'(bus_read_data[15:8]);
      if (bus_read_data[1]) saw_done = 1'b1;
    end
    bus_read_en = 1'b0;
    checks++;
    if (nwr != 12) begin errors++; $display("FAIL loop_nwr: got %0d required 12", nwr); end
    checks++;
    if (saw_wrap !== 1'b1) begin errors++; $display("FAIL loop_step_wrap: got %b required 1", saw_wrap); end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL loop_no_done: got %b required 0", saw_done); end
    bus_wr(A_CTRL, 32'h0302);
    repeat (8) @(negedge pclk);
    bus_rd(A_STATUS, d);
    checks++;
    if (d[1:0] !== 2'b00) begin errors++; $display("FAIL loop_stop: got %b required 00", d[1:0]); end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic found = 1'b0;
    int nwr = 0;
    bus_wr(A_TICKS, 32'd4);
    bus_wr(A_CTRL, 32'h0301);
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      if (led_write_en && led_addr == 8'h04) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL abort_wr1_seen: got %b required 1", found); end
    bus_write_en   = 1'b1;
    bus_addr       = A_CTRL;
    bus_write_data = 32'h0300;
    @(negedge pclk);
    bus_write_en = 1'b0;
    checks++;
    if ({led_write_en, led_addr, led_write_data} !== {1'b1, 8'h08, pat[1]}) begin
      errors++;
      $display("FAIL abort_wr2: got en=%b addr=%h data=%h required en=1 addr=08 data=%h",
               led_write_en, led_addr, led_write_data, pat[1]);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge pclk);
      if (led_write_en) nwr++;
    end
    checks++;
    if (nwr != 0) begin errors++; $display("FAIL abort_no_writes: got %0d required 0", nwr); end
    bus_rd(A_STATUS, d);
    checks++;
    if (d[1:0] !== 2'b00) begin errors++; $display("FAIL abort_status: got %b required 00", d[1:0]); end
  endtask

  task automatic test_zero_steps();
    logic [31:0] d;
    int nwr = 0;
    bus_wr(A_CTRL, 32'h0005);
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      if (led_write_en) nwr++;
    end
    checks++;
    if (nwr != 0) begin errors++; $display("FAIL zero_no_writes: got %0d required 0", nwr); end
    bus_rd(A_STATUS, d);
    checks++;
    if (d[1:0] !== 2'b10) begin errors++; $display("FAIL zero_done: got %b required 10", d[1:0]); end
    bus_rd(A_CTRL, d);
`ifdef LED_SEQ_IRQ_EN
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL zero_ctrl: got %h required 00000004", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b required 1", irq); end
`else
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL zero_ctrl: got %h required 0", d); end
`endif
    bus_wr(A_STATUS, 32'h2);
`ifdef LED_SEQ_IRQ_EN
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_lag: got %b required 1", irq); end
    @(negedge pclk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b required 0", irq); end
`endif
    bus_rd(A_STATUS, d);
    checks++;
    if (d[1] !== 1'b0) begin errors++; $display("FAIL zero_w1c: got %b required 0", d[1]); end
    bus_wr(A_CTRL, 32'h0);
  endtask

  task automatic test_reset_mid_dwell();
    logic [31:0] d;
    logic found = 1'b0;
    int nwr = 0;
    int done_k = -1;
    bus_wr(A_TICKS, 32'd10);
    bus_wr(A_CTRL, 32'h0101);
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      if (led_write_en && led_addr == 8'h08) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL rst_wr2_seen: got %b required 1", found); end
    repeat (2) @(negedge pclk);
    nreset = 1'b0;
    #1;
    checks++;
    if ({led_write_en, led_addr, led_write_data, bus_read_data} !== 73'h0) begin
      errors++;
      $display("FAIL rst_outputs: got en=%b addr=%h data=%h rd=%h required all 0",
               led_write_en, led_addr, led_write_data, bus_read_data);
    end
    @(negedge pclk);
    nreset = 1'b1;
    bus_rd(A_STATUS, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_status: got %h required 0", d); end
    bus_rd(A_TICKS, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_ticks: got %h required 0", d); end
    bus_rd(A_DATA, d);
    checks++;
    if (d !== pat[0]) begin errors++; $display("FAIL ram_kept0: got %h required %h", d, pat[0]); end
    bus_wr(A_PTR, 32'd5);
    bus_rd(A_DATA, d);
    checks++;
    if (d !== pat[5]) begin errors++; $display("FAIL ram_kept5: got %h required %h", d, pat[5]); end
    bus_wr(A_CTRL, 32'h0101);
    bus_addr    = A_STATUS;
    bus_read_en = 1'b1;
    for (int k = 2; k <= 10; k++) begin
      @(negedge pclk);
      if (led_write_en) begin
        checks++;
        if (nwr == 0 && {k[7:0], led_addr, led_write_data} !== {8'd3, 8'h04, pat[0]}) begin
          errors++;
          $display("FAIL rerun_wr1: got k=%0d addr=%h data=%h required k=3 addr=04 data=%h",
                   k, led_addr, led_write_data, pat[0]);
        end
        if (nwr == 1 && {k[7:0], led_addr, led_write_data} !== {8'd4, 8'h08, pat[1]}) begin
          errors++;
          $display("FAIL rerun_wr2: got k=%0d addr=%h data=%h required k=4 addr=08 data=%h",
                   k, led_addr, led_write_data, pat[1]);
        end
        nwr++;
      end
      if (bus_read_data[1] && done_k < 0) done_k = k;
    end
    bus_read_en = 1'b0;
    checks++;
    if (nwr != 2 || done_k != 7) begin
      errors++;
      $display("FAIL rerun_zero_ticks: got nwr=%0d done_k=%0d required 2 and 7", nwr, done_k);
    end
    bus_wr(A_STATUS, 32'h2);
  endtask

  task automatic test_fetch_collision();
    logic [31:0] d;
    logic found = 1'b0;
    logic [31:0] new_word = 32'h8ABCDEF0;
    bus_wr(A_PTR, 32'h0);
    bus_wr(A_TICKS, 32'd3);
    bus_wr(A_CTRL, 32'h0103);
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      if (led_write_en && led_addr == 8'h04) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL coll_wr1_seen: got %b required 1", found); end
    repeat (5) @(negedge pclk);
    bus_write_en   = 1'b1;
    bus_addr       = A_DATA;
    bus_write_data = new_word;
    @(negedge pclk);
    bus_write_en = 1'b0;
    checks++;
    if ({led_write_en, led_addr, led_write_data} !== {1'b1, 8'h04, pat[0]}) begin
      errors++;
      $display("FAIL coll_old: got en=%b addr=%h data=%h required en=1 addr=04 data=%h",
               led_write_en, led_addr, led_write_data, pat[0]);
    end
    repeat (6) @(negedge pclk);
    checks++;
    if ({led_write_en, led_addr, led_write_data} !== {1'b1, 8'h04, new_word}) begin
      errors++;
      $display("FAIL coll_new: got en=%b addr=%h data=%h required en=1 addr=04 data=%h",
               led_write_en, led_addr, led_write_data, new_word);
    end
    bus_wr(A_CTRL, 32'h0);
    repeat (10) @(negedge pclk);
    bus_rd(A_STATUS, d);
    checks++;
    if (d[1:0] !== 2'b00) begin errors++; $display("FAIL coll_stop: got %b required 00", d[1:0]); end
  endtask

  initial begin
    test_reset();
    test_registers();
    test_single_step();
    test_loop();
    test_abort();
    test_zero_steps();
    test_reset_mid_dwell();
    test_fetch_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
